gpr_wb_arbiter: RTL and testbench
=================================

# gpr_wb_arbiter

Write-back arbiter and pending-write scoreboard in front of the general-purpose register file's single write port. It accepts result write requests from `NUM_REQ` execution units over valid/ready handshakes and grants one per cycle. Grants are round-robin or fixed-priority. The granted write is registered onto the register file's `rd` write interface. Per-register busy bits are tracked from issue to write-back so that decode can stall on read-after-write hazards.

## Interface
Parameters:
- `REG_ADDR_BUS_WIDTH`, 5, register address width.
- `REG_DATA_BUS_WIDTH`, 32, register data width.
- `NUMBER_OF_GPR`, 32, number of registers; x0 is hardwired to zero.
- `NUM_REQ`, 3, number of write-back requesters (2..8).

Ports:
- `i_clk`  in  1  clock.
- `i_nrst`  in  1  reset, asynchronous, active-low.
- `i_req_valid`  in  NUM_REQ  per-requester write request valid.
- `o_req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `i_req_addr`  in  NUM_REQ*REG_ADDR_BUS_WIDTH  packed destination addresses; requester k occupies slice k.
- `i_req_data`  in  NUM_REQ*REG_DATA_BUS_WIDTH  packed write data.
- `o_rd_we`  out  1  register file write enable, registered.
- `o_rd_addr`  out  REG_ADDR_BUS_WIDTH  register file write address, registered.
- `o_rd_w_data`  out  REG_DATA_BUS_WIDTH  register file write data, registered.
- `i_iss_valid`  in  1  an instruction writing `i_iss_addr` issues this cycle.
- `i_iss_addr`  in  REG_ADDR_BUS_WIDTH  destination of the issuing instruction.
- `i_rs1_addr`, `i_rs2_addr`  in  REG_ADDR_BUS_WIDTH  source addresses being decoded.
- `o_rs1_busy`, `o_rs2_busy`  out  1  source register has a pending write.

## Operation
- Arbitration is combinational from `i_req_valid` and the priority state. At most one `o_req_ready` bit is high, and only for a valid requester.
- `o_req_ready` never depends on `i_req_data` or `i_req_addr`.
- A handshake completes when `valid && ready`. The accepted address and data load into the output register.
- `o_rd_we` is 1 the next cycle if the accepted address is nonzero. It is 0 if the address is x0: the request is consumed and silently dropped.
- With no handshake, `o_rd_we` is 0 the next cycle. `o_rd_addr` and `o_rd_w_data` hold their last values.
- Scoreboard: register `busy[NUMBER_OF_GPR-1:1]`; busy for x0 is constant 0.
  - Set: `i_iss_valid` with nonzero `i_iss_addr` sets `busy[i_iss_addr]`.
  - Clear: `o_rd_we` high clears `busy[o_rd_addr]`, i.e. in the cycle the register file actually writes.
  - Same address set and cleared in one cycle: set wins.
- `o_rsN_busy = busy[i_rsN_addr]`, combinational. Address 0 always reads 0.
- Requesters must not present a write whose issue was never recorded. A clear of a non-busy bit is harmless.

## Timing
- Reset values: `o_rd_we` 0, `o_rd_addr` 0, `o_rd_w_data` 0, all busy bits 0, round-robin pointer `NUM_REQ-1` (requester 0 has highest priority first).
- With reset asserted, `o_req_ready` is 0 and `o_rsN_busy` is 0.
- Latency:
  - Handshake in cycle N gives `o_rd_we` in cycle N+1. The register file updates at the end of N+1.
  - The busy bit reads 0 from cycle N+2, so decode never reads stale data.
- Throughput: one write per cycle, with no bubbles under continuous requests.
- Reset mid-operation: a pending registered write is discarded and all busy bits are cleared asynchronously. The pipeline must be flushed alongside.

## Configuration
- `GPR_WB_RR_EN` defined: round-robin arbitration.
  - The search starts at pointer+1 modulo `NUM_REQ`.
  - The pointer updates to the granted index only on a completed handshake.
  - A requester held valid is granted within `NUM_REQ` cycles.
- `GPR_WB_RR_EN` undefined: fixed priority, lowest index wins. The pointer register is not instantiated.

## Test plan
- Reset: assert `i_nrst`=0 mid-stream with a write pending → `o_rd_we`=0, busy all 0 immediately. After release, req0 (addr 5, data `0xDEADBEEF`) → `o_rd_we`=1, `o_rd_addr`=5, `o_rd_w_data`=`0xDEADBEEF` one cycle later.
- Round-robin: all three requesters valid continuously (addrs 1,2,3) → grants 0,1,2,0,1,2 on consecutive cycles; `o_rd_we` high every cycle from cycle 1. Without the macro → grants 0,0,0,…
- x0 drop: req1 to addr 0 with data `0x1234` → `o_req_ready[1]`=1, next cycle `o_rd_we`=0.
- Scoreboard: issue addr 7 in cycle 0 → `o_rs1_busy`=1 for `i_rs1_addr`=7 from cycle 1. req2 accepted for addr 7 in cycle 4 → `o_rd_we` in cycle 5, busy=0 from cycle 6.
- Set/clear collision: `o_rd_we` writing addr 9 while `i_iss_valid` with addr 9 in the same cycle → busy[9] stays 1.
- Backpressure fairness (RR): req0 and req2 valid, req0 deasserts after its grant → next grant goes to req2. Ready is never asserted to an invalid requester.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
// Write-back arbiter and pending-write scoreboard in front of the GPR file's
// single write port. Execution units request writes over valid/ready
// handshakes. One request is granted per cycle, and the granted write is
// registered onto the rd interface. Busy bits track destinations from issue
// to write-back so that decode can stall on read-after-write hazards.
//
// Optional feature: define GPR_WB_RR_EN for round-robin arbitration. When it
// is undefined, arbitration is fixed priority (lowest index wins) and no
// pointer register exists.
module gpr_wb_arbiter #(
  parameter int REG_ADDR_BUS_WIDTH = 5,
  parameter int REG_DATA_BUS_WIDTH = 32,
  parameter int NUMBER_OF_GPR      = 32,
  parameter int NUM_REQ            = 3
) (
  input  logic                                   i_clk,
  input  logic                                   i_nrst,
  input  logic [NUM_REQ-1:0]                     i_req_valid,
  output logic [NUM_REQ-1:0]                     o_req_ready,
  input  logic [NUM_REQ*REG_ADDR_BUS_WIDTH-1:0]  i_req_addr,
  input  logic [NUM_REQ*REG_DATA_BUS_WIDTH-1:0]  i_req_data,
  output logic                                   o_rd_we,
  output logic [REG_ADDR_BUS_WIDTH-1:0]          o_rd_addr,
  output logic [REG_DATA_BUS_WIDTH-1:0]          o_rd_w_data,
  input  logic                                   i_iss_valid,
  input  logic [REG_ADDR_BUS_WIDTH-1:0]          i_iss_addr,
  input  logic [REG_ADDR_BUS_WIDTH-1:0]          i_rs1_addr,
  input  logic [REG_ADDR_BUS_WIDTH-1:0]          i_rs2_addr,
  output logic                                   o_rs1_busy,
  output logic                                   o_rs2_busy
);

  localparam int AW    = REG_ADDR_BUS_WIDTH;
  localparam int DW    = REG_DATA_BUS_WIDTH;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                     grant_any;
  logic [IDX_W-1:0]         grant_idx;
  logic [NUM_REQ-1:0]       grant;
  logic [AW-1:0]            sel_addr;
  logic [DW-1:0]            sel_data;
  logic [NUMBER_OF_GPR-1:1] busy;

`ifdef GPR_WB_RR_EN
  logic [IDX_W-1:0] rr_ptr;

  // Round-robin: search requesters above the pointer first, then wrap to the low ones
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_any && i_req_valid[j] && (j > int'(rr_ptr))) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_any && i_req_valid[j] && (j <= int'(rr_ptr))) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  // Pointer remembers the last granted requester; it moves only on a handshake
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (grant_any) begin
      rr_ptr <= grant_idx;
    end
  end
`else
  // Fixed priority: the lowest-indexed valid requester wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_any && i_req_valid[j]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end
`endif

  // Ready depends only on valid bits and priority state, and is forced low while in reset
  assign grant       = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  assign o_req_ready = i_nrst ? grant : '0;

  // Select the granted requester's address and data for the output register
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_idx == IDX_W'(j)) begin
        sel_addr = i_req_addr[j*AW +: AW];
        sel_data = i_req_data[j*DW +: DW];
      end
    end
  end

  // Register the accepted write; writes to x0 are consumed but never enabled
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_rd_we     <= 1'b0;
      o_rd_addr   <= '0;
      o_rd_w_data <= '0;
    end else if (grant_any) begin
      o_rd_we     <= (sel_addr != '0);
      o_rd_addr   <= sel_addr;
      o_rd_w_data <= sel_data;
    end else begin
      o_rd_we     <= 1'b0;
    end
  end

  // Busy bits: set on issue, cleared when the register file writes; set wins on collision
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      busy <= '0;
    end else begin
      for (int r = 1; r < NUMBER_OF_GPR; r++) begin
        if (i_iss_valid && (i_iss_addr == AW'(r))) begin
          busy[r] <= 1'b1;
        end else if (o_rd_we && (o_rd_addr == AW'(r))) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  // Combinational busy lookup for the two decode source ports; x0 is never busy
  always_comb begin
    o_rs1_busy = 1'b0;
    o_rs2_busy = 1'b0;
    for (int r = 1; r < NUMBER_OF_GPR; r++) begin
      if (i_rs1_addr == AW'(r)) o_rs1_busy = busy[r];
      if (i_rs2_addr == AW'(r)) o_rs2_busy = busy[r];
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter
// Self-checking bench for gpr_wb_arbiter. A behavioural model holds the busy
// set, the expected registered write and the arbitration pointer. Directed
// scenarios come first, followed by randomized traffic. Honors GPR_WB_RR_EN
// the same way the design does.
module tb_gpr_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NG = 32;
  localparam int NR = 3;

  logic             i_clk = 1'b0;
  logic             i_nrst;
  logic [NR-1:0]    i_req_valid;
  logic [NR-1:0]    o_req_ready;
  logic [NR*AW-1:0] i_req_addr;
  logic [NR*DW-1:0] i_req_data;
  logic             o_rd_we;
  logic [AW-1:0]    o_rd_addr;
  logic [DW-1:0]    o_rd_w_data;
  logic             i_iss_valid;
  logic [AW-1:0]    i_iss_addr;
  logic [AW-1:0]    i_rs1_addr;
  logic [AW-1:0]    i_rs2_addr;
  logic             o_rs1_busy;
  logic             o_rs2_busy;

  int vectors     = 0;
  int miscompares = 0;

  bit            model_busy [NG];
  logic          model_we;
  logic [AW-1:0] model_addr;
  logic [DW-1:0] model_data;
`ifdef GPR_WB_RR_EN
  int            model_ptr;
`endif

  gpr_wb_arbiter #(
    .REG_ADDR_BUS_WIDTH (AW),
    .REG_DATA_BUS_WIDTH (DW),
    .NUMBER_OF_GPR      (NG),
    .NUM_REQ            (NR)
  ) dut (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr  (i_req_addr),
    .i_req_data  (i_req_data),
    .o_rd_we     (o_rd_we),
    .o_rd_addr   (o_rd_addr),
    .o_rd_w_data (o_rd_w_data),
    .i_iss_valid (i_iss_valid),
    .i_iss_addr  (i_iss_addr),
    .i_rs1_addr  (i_rs1_addr),
    .i_rs2_addr  (i_rs2_addr),
    .o_rs1_busy  (o_rs1_busy),
    .o_rs2_busy  (o_rs2_busy)
  );

  // Free-running clock with a 10 ns period
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
    end
  endtask

  // Expected grant index, or -1 when no requester is valid
  function automatic int modelGrant(input logic [NR-1:0] v);
    int j;
`ifdef GPR_WB_RR_EN
    for (int k = 1; k <= NR; k++) begin
      j = (model_ptr + k) % NR;
      if (v[j]) return j;
    end
`else
    for (j = 0; j < NR; j++) begin
      if (v[j]) return j;
    end
`endif
    return -1;
  endfunction

  task automatic modelReset();
    foreach (model_busy[r]) model_busy[r] = 1'b0;
    model_we   = 1'b0;
    model_addr = '0;
    model_data = '0;
`ifdef GPR_WB_RR_EN
    model_ptr  = NR - 1;
`endif
  endtask

  // Applies one cycle of inputs starting at posedge+1, checks the
  // combinational outputs mid-cycle, then checks the registered outputs after the edge
  task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                               input logic [NR*DW-1:0] d, input logic iv,
                               input logic [AW-1:0] ia, input logic [AW-1:0] r1,
                               input logic [AW-1:0] r2);
    int            g;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    i_req_valid = v;
    i_req_addr  = a;
    i_req_data  = d;
    i_iss_valid = iv;
    i_iss_addr  = ia;
    i_rs1_addr  = r1;
    i_rs2_addr  = r2;
    #3;
    g = modelGrant(v);
    checkOutput("req_ready", DW'(o_req_ready), (g >= 0) ? DW'(1 << g) : 32'd0);
    checkOutput("rs1_busy", DW'(o_rs1_busy), DW'(model_busy[r1]));
    checkOutput("rs2_busy", DW'(o_rs2_busy), DW'(model_busy[r2]));
    if (model_we) model_busy[model_addr] = 1'b0;
    if (iv && (ia != '0)) model_busy[ia] = 1'b1;
    if (g >= 0) begin
      ga         = a[g*AW +: AW];
      gd         = d[g*DW +: DW];
      model_we   = (ga != '0);
      model_addr = ga;
      model_data = gd;
`ifdef GPR_WB_RR_EN
      model_ptr  = g;
`endif
    end else begin
      model_we = 1'b0;
    end
    @(posedge i_clk);
    #1;
    checkOutput("rd_we", DW'(o_rd_we), DW'(model_we));
    checkOutput("rd_addr", DW'(o_rd_addr), DW'(model_addr));
    checkOutput("rd_w_data", o_rd_w_data, model_data);
  endtask

  // Main stimulus sequence: directed scenarios, then randomized traffic
  initial begin
    i_nrst      = 1'b0;
    i_req_valid = 3'b111;
    i_req_addr  = '0;
    i_req_data  = '0;
    i_iss_valid = 1'b0;
    i_iss_addr  = '0;
    i_rs1_addr  = 5'd7;
    i_rs2_addr  = 5'd0;
    modelReset();
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset_rd_we", DW'(o_rd_we), 32'd0);
    checkOutput("reset_rd_addr", DW'(o_rd_addr), 32'd0);
    checkOutput("reset_rd_w_data", o_rd_w_data, 32'd0);
    checkOutput("reset_ready", DW'(o_req_ready), 32'd0);
    checkOutput("reset_busy", DW'(o_rs1_busy), 32'd0);
    i_req_valid = '0;
    i_nrst      = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'b111, {5'd3, 5'd2, 5'd1},
                    {32'hC000_0000 + i, 32'hB000_0000 + i, 32'hA000_0000 + i}, 1'b0, '0, 5'd1, 5'd2);
    end

    applyStimulus(3'b101, {5'd4, 5'd0, 5'd6}, {32'h44, 32'h0, 32'h66}, 1'b0, '0, 5'd0, 5'd0);
    applyStimulus(3'b100, {5'd4, 5'd0, 5'd6}, {32'h44, 32'h0, 32'h66}, 1'b0, '0, 5'd0, 5'd0);

    applyStimulus(3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234, 32'h0}, 1'b0, '0, 5'd0, 5'd0);

    applyStimulus(3'b000, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, '0, '0, 1'b0, '0, 5'd7, 5'd0);
    applyStimulus(3'b100, {5'd7, 5'd0, 5'd0}, {32'h7777, 32'h0, 32'h0}, 1'b0, '0, 5'd7, 5'd0);
    for (int i = 0; i < 2; i++) applyStimulus(3'b000, '0, '0, 1'b0, '0, 5'd7, 5'd0);

    applyStimulus(3'b000, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
    applyStimulus(3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h9999}, 1'b0, '0, 5'd9, 5'd9);
    applyStimulus(3'b000, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
    applyStimulus(3'b000, '0, '0, 1'b0, '0, 5'd9, 5'd9);
    checkOutput("collision_busy9", DW'(o_rs1_busy), 32'd1);

    applyStimulus(3'b000, '0, '0, 1'b1, 5'd12, 5'd0, 5'd0);
    applyStimulus(3'b001, {5'd0, 5'd0, 5'd12}, {32'h0, 32'h0, 32'h5555}, 1'b0, '0, 5'd12, 5'd0);
    i_nrst      = 1'b0;
    i_req_valid = 3'b111;
    i_rs1_addr  = 5'd12;
    #1;
    checkOutput("midrst_rd_we", DW'(o_rd_we), 32'd0);
    checkOutput("midrst_busy12", DW'(o_rs1_busy), 32'd0);
    checkOutput("midrst_ready", DW'(o_req_ready), 32'd0);
    modelReset();
    @(posedge i_clk);
    #1;
    i_nrst      = 1'b1;
    i_req_valid = '0;
    applyStimulus(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEAD_BEEF}, 1'b0, '0, 5'd0, 5'd0);
    checkOutput("post_rst_addr", DW'(o_rd_addr), 32'd5);
    checkOutput("post_rst_data", o_rd_w_data, 32'hDEAD_BEEF);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(NR'($urandom_range(0, 7)),
                    {AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31))},
                    {32'($urandom), 32'($urandom), 32'($urandom)},
                    1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                    AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
